// File: rtl/conv_window_seq.sv
// Sequencer for a KxK convolution window built from row delay lines: accepts one raster frame
// per start, advances the delay lines and flags each cycle a complete window sits at the taps.
module conv_window_seq #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3,
    parameter int CW    = 5
) (
    input  logic          i_clk,
    input  logic          i_reset_b,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_pix_valid,
    output logic          o_in_ready,
    output logic          o_shift_en,
    output logic          o_win_valid,
    output logic [CW-1:0] o_win_row,
    output logic [CW-1:0] o_win_col,
    output logic          o_busy,
    output logic          o_frame_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] KM1      = CW'(K - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_in_ready;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic          r_win_valid;
    logic [CW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;

    logic          w_accept;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_frame_end;
    logic          w_win_hit;

    // abort wins over an accept in the same cycle: the pixel is dropped, not counted
    assign w_accept    = i_pix_valid & r_in_ready & ~i_abort;
    assign w_col_last  = (r_col == COL_LAST);
    assign w_row_last  = (r_row == ROW_LAST);
    assign w_frame_end = w_accept & w_col_last & w_row_last;
    assign w_win_hit   = w_accept & (r_row >= KM1) & (r_col >= KM1);

    always_ff @(posedge i_clk) begin
        if (!i_reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_start) w_state_nxt = S_RUN;
                S_RUN:   if (w_frame_end) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_frame_done = (r_state == S_DONE);
        o_in_ready   = r_in_ready;
        o_shift_en   = i_pix_valid & r_in_ready;
        o_win_valid  = r_win_valid;
        o_win_row    = r_win_row;
        o_win_col    = r_win_col;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_b) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == S_RUN);
        end
    end

    // Last pixel wraps both counters to zero, so they are already clear on entry to DONE
    always_ff @(posedge i_clk) begin
        if (!i_reset_b) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_abort || (r_state == S_IDLE)) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_b) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else begin
            r_win_valid <= w_win_hit;
            if (w_win_hit) begin
                r_win_row <= r_row - KM1;
                r_win_col <= r_col - KM1;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_seq.sv
// Bench for conv_window_seq: frame-level vector table with a window scoreboard, plus a
// small K=5 8x8 instance.
module tb_conv_window_seq;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int KK = 3;

    logic       clk = 1'b0;
    logic       i_reset_b = 1'b0;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic       i_pix_valid = 1'b0;
    logic       o_in_ready, o_shift_en, o_win_valid, o_busy, o_frame_done;
    logic [4:0] o_win_row, o_win_col;

    logic       b_reset_b = 1'b0;
    logic       b_start = 1'b0;
    logic       b_abort = 1'b0;
    logic       b_pix_valid = 1'b0;
    logic       b_in_ready, b_shift_en, b_win_valid, b_busy, b_frame_done;
    logic [4:0] b_win_row, b_win_col;

    always #5 clk = ~clk;

    conv_window_seq #(.IMG_W(W), .IMG_H(H), .K(KK), .CW(5)) dut (
        .i_clk(clk), .i_reset_b(i_reset_b), .i_start(i_start), .i_abort(i_abort),
        .i_pix_valid(i_pix_valid), .o_in_ready(o_in_ready), .o_shift_en(o_shift_en),
        .o_win_valid(o_win_valid), .o_win_row(o_win_row), .o_win_col(o_win_col),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    conv_window_seq #(.IMG_W(8), .IMG_H(8), .K(5), .CW(5)) dut_b (
        .i_clk(clk), .i_reset_b(b_reset_b), .i_start(b_start), .i_abort(b_abort),
        .i_pix_valid(b_pix_valid), .o_in_ready(b_in_ready), .o_shift_en(b_shift_en),
        .o_win_valid(b_win_valid), .o_win_row(b_win_row), .o_win_col(b_win_col),
        .o_busy(b_busy), .o_frame_done(b_frame_done)
    );

    typedef struct {
        bit toggle;
        int abort_at;
        int rst_at;
        int start_run_at;
        bit start_done;
        int exp_win;
        int exp_done;
    } frame_vec_t;

    int n_vec = 0;
    int n_err = 0;
    int q[$];
    int win_cnt = 0;
    int first_at = -1;
    int n_acc = 0;
    int fd_cnt = 0;
    int last_rc = 0;
    bit mon_en = 1'b0;
    bit prev_pv = 1'b0;

    int b_cnt = 0;
    int b_first = -1;
    int b_last = -1;
    int b_fd = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) prev_pv <= i_pix_valid;

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_frame_done) fd_cnt++;
            if (o_win_valid) begin
                chk("win_after_stall", int'(prev_pv), 1);
                if (first_at < 0) first_at = n_acc;
                win_cnt++;
                last_rc = int'(o_win_row) * 256 + int'(o_win_col);
                if (q.size() == 0) begin
                    chk("win_unexpected", 1, 0);
                end else begin
                    chk("win_coord", last_rc, q.pop_front());
                end
            end else begin
                chk("win_hold", int'(o_win_row) * 256 + int'(o_win_col), last_rc);
            end
        end
    end

    always @(negedge clk) begin
        if (b_reset_b && b_win_valid) begin
            if (b_cnt == 0) b_first = int'(b_win_row) * 256 + int'(b_win_col);
            b_cnt++;
            b_last = int'(b_win_row) * 256 + int'(b_win_col);
        end
        if (b_reset_b && b_frame_done) b_fd++;
    end

    task automatic run_frame(input frame_vec_t v);
        int  cyc = 0;
        int  row = 0;
        int  col = 0;
        bit  run = 1'b1;
        bit  done = 1'b0;
        bit  pv;
        int  fd0;
        fd0 = fd_cnt;
        win_cnt = 0;
        first_at = -1;
        n_acc = 0;
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        chk("in_ready_after_start", int'(o_in_ready), 1);
        while (run && cyc < 4000) begin
            pv = v.toggle ? ((cyc % 2) == 0) : 1'b1;
            i_start = pv && (n_acc == v.start_run_at);
            if (pv && n_acc == v.abort_at) begin
                i_abort = 1'b1;
                i_pix_valid = 1'b1;
                @(posedge clk); #1;
                i_abort = 1'b0;
                i_pix_valid = 1'b0;
                chk("abort_in_ready", int'(o_in_ready), 0);
                chk("abort_busy", int'(o_busy), 0);
                run = 1'b0;
            end else if (pv && n_acc == v.rst_at) begin
                i_reset_b = 1'b0;
                i_pix_valid = 1'b1;
                @(posedge clk); #1;
                i_reset_b = 1'b1;
                last_rc = 0;
                @(negedge clk);
                chk("rst_in_ready", int'(o_in_ready), 0);
                chk("rst_busy", int'(o_busy), 0);
                chk("rst_win_valid", int'(o_win_valid), 0);
                chk("rst_frame_done", int'(o_frame_done), 0);
                chk("rst_win_rc", int'(o_win_row) * 256 + int'(o_win_col), 0);
                repeat (4) @(posedge clk);
                #1 chk("rst_pixels_ignored", int'(o_in_ready), 0);
                i_pix_valid = 1'b0;
                run = 1'b0;
            end else begin
                i_pix_valid = pv;
                if (pv && row >= KK - 1 && col >= KK - 1)
                    q.push_back((row - (KK - 1)) * 256 + (col - (KK - 1)));
                @(posedge clk); #1;
                i_start = 1'b0;
                if (pv) begin
                    n_acc++;
                    if (col == W - 1) begin
                        col = 0;
                        if (row == H - 1) begin
                            run = 1'b0;
                            done = 1'b1;
                        end
                        row++;
                    end else begin
                        col++;
                    end
                end
                cyc++;
            end
        end
        i_pix_valid = 1'b0;
        i_start = 1'b0;
        if (cyc >= 4000) chk("frame_timeout", 0, 1);
        if (done) begin
            i_start = v.start_done;
            @(negedge clk);
            chk("done_frame_done", int'(o_frame_done), 1);
            chk("done_in_ready", int'(o_in_ready), 0);
            chk("done_busy", int'(o_busy), 1);
            chk("done_accepts", n_acc, W * H);
            @(posedge clk); #1 i_start = 1'b0;
            @(negedge clk);
            chk("idle_busy", int'(o_busy), 0);
            chk("idle_frame_done", int'(o_frame_done), 0);
        end else begin
            repeat (3) @(posedge clk);
            #1;
        end
        chk("window_count", win_cnt, v.exp_win);
        chk("frame_done_count", fd_cnt - fd0, v.exp_done);
        chk("queue_empty", q.size(), 0);
        if (v.exp_win > 0) chk("first_window_accept", first_at, (KK - 1) * W + KK);
        q.delete();
    endtask

    frame_vec_t vecs[7];

    initial begin
        vecs[0] = '{0, -1, -1, -1, 0, 676, 1};
        vecs[1] = '{1, -1, -1, -1, 0, 676, 1};
        vecs[2] = '{0, 300, -1, -1, 0, 226, 0};
        vecs[3] = '{0, -1, -1, -1, 0, 676, 1};
        vecs[4] = '{1, -1, 400, -1, 0, 318, 0};
        vecs[5] = '{0, -1, -1, 100, 1, 676, 1};
        vecs[6] = '{0, -1, -1, -1, 0, 676, 1};

        repeat (3) @(posedge clk);
        #1 i_reset_b = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        chk("reset_in_ready", int'(o_in_ready), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_win_valid", int'(o_win_valid), 0);
        chk("reset_frame_done", int'(o_frame_done), 0);

        i_pix_valid = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_shift", int'(o_shift_en), 0);
        i_pix_valid = 1'b0;

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        @(posedge clk); #1 b_reset_b = 1'b1;
        b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        b_pix_valid = 1'b1;
        repeat (64) @(posedge clk);
        #1 b_pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("k5_window_count", b_cnt, 16);
        chk("k5_first_window", b_first, 0);
        chk("k5_last_window", b_last, 3 * 256 + 3);
        chk("k5_frame_done", b_fd, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
